// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared constants for the scaler stage blocks
package scaler_pkg;

    localparam int STAGES_DEFAULT = 12;
    localparam int FIRST_STAGE    = 3;

    // Synchronizer depth plus edge flop; edges are ignored until it is full.
    localparam int ARM_CYCLES     = 3;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer, rising-edge detector and arm counter
module sync_edge
    import scaler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic arm_ok,
    output logic rise
);

    localparam logic [1:0] ARM_DONE = 2'(ARM_CYCLES);

    logic       s1_q;
    logic       s2_q;
    logic       s3_q;
    logic [1:0] arm_q;
    logic [1:0] arm_d;

    always_comb begin
        arm_d = arm_q;
        if (arm_q != ARM_DONE) begin
            arm_d = arm_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            arm_q <= 2'd0;
        end else begin
            s1_q  <= d;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            arm_q <= arm_d;
        end
    end

    // A level already high at reset release reaches s2 before the arm count
    // completes, so it can never be seen as an edge.
    assign arm_ok = (arm_q == ARM_DONE);
    assign rise   = arm_ok & s2_q & ~s3_q;

endmodule

// File: rtl/scaler_stages.sv
// rtl/scaler_stages.sv - binary scaler stages FS03.. driven by synchronized FS02 edges
module scaler_stages
    import scaler_pkg::*;
#(
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FS02,
    input  logic              hold,
    output logic [STAGES-1:0] FS,
    output logic [STAGES-1:0] FA,
    output logic [STAGES-1:0] FB,
    output logic              CARRY
);

    localparam logic [STAGES-1:0] ONE = STAGES'(1);

    logic              arm_ok;
    logic              rise;
    logic              accept;
    logic [STAGES-1:0] fs_q;
    logic [STAGES-1:0] fs_d;
    logic [STAGES-1:0] fa_q;
    logic [STAGES-1:0] fa_d;
    logic [STAGES-1:0] fb_q;
    logic [STAGES-1:0] fb_d;
    logic              carry_q;
    logic              carry_d;

    sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .d      (FS02),
        .arm_ok (arm_ok),
        .rise   (rise)
    );

    // Edges seen under hold are consumed here, not queued for later.
    assign accept = rise & arm_ok & ~hold;

    always_comb begin
        fs_d    = fs_q;
        fa_d    = '0;
        fb_d    = '0;
        carry_d = 1'b0;
        if (accept) begin
            fs_d    = fs_q + ONE;
            fa_d    = ~fs_q & fs_d;
            fb_d    = fs_q & ~fs_d;
            carry_d = &fs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_q    <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            fs_q    <= fs_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            carry_q <= carry_d;
        end
    end

    assign FS    = fs_q;
    assign FA    = fa_q;
    assign FB    = fb_q;
    assign CARRY = carry_q;

endmodule

// File: tb/tb_scaler_stages.sv
// tb/tb_scaler_stages.sv - self-checking bench for scaler_stages
module tb_scaler_stages;

    localparam int N = 12;
    localparam logic [N-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         FS02;
    logic         hold;
    logic [N-1:0] FS;
    logic [N-1:0] FA;
    logic [N-1:0] FB;
    logic         CARRY;

    scaler_stages #(.STAGES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .FS02  (FS02),
        .hold  (hold),
        .FS    (FS),
        .FA    (FA),
        .FB    (FB),
        .CARRY (CARRY)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an FS02 level first sampled high two edges ago after
    // a low sample is a new edge; it counts only with hold low and at least
    // three reset-free edges behind it.
    logic [N-1:0] m_fs;
    logic [N-1:0] m_fa;
    logic [N-1:0] m_fb;
    logic [N-1:0] m_old;
    logic         m_carry;
    bit           m_valid = 0;
    bit           hist [0:3];
    int           low_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_fs = '0; m_fa = '0; m_fb = '0; m_carry = 1'b0;
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            low_cnt = 0;
            m_valid = 1;
        end else if (m_valid) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = FS02;
            m_fa = '0; m_fb = '0; m_carry = 1'b0;
            if (hist[2] && !hist[3] && low_cnt >= 3 && !hold) begin
                m_old   = m_fs;
                m_fs    = m_fs + N'(1);
                m_fa    = m_fs & ~m_old;
                m_fb    = m_old & ~m_fs;
                m_carry = (m_old == ONES);
            end
            low_cnt++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_FS", 32'(FS), 32'(m_fs));
            chk("model_FA", 32'(FA), 32'(m_fa));
            chk("model_FB", 32'(FB), 32'(m_fb));
            chk("model_CARRY", 32'(CARRY), 32'(m_carry));
        end
    end

    int           any_pulse = 0;
    int           carry_cnt = 0;
    logic [N-1:0] fb_at_carry = '0;

    always @(negedge clk) begin
        if (CARRY === 1'b1) begin
            carry_cnt++;
            fb_at_carry = FB;
        end
        if ((FA | FB) !== '0 || CARRY === 1'b1) any_pulse++;
    end

    task automatic edge_cycle();
        FS02 = 1'b1;
        repeat (4) @(negedge clk);
        FS02 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; FS02 = 1'b1; hold = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        any_pulse = 0;
        repeat (20) @(negedge clk);
        chk("fs02_high_at_release_FS", 32'(FS), 32'h000);
        chk("fs02_high_at_release_pulses", 32'(any_pulse), 32'd0);
        FS02 = 1'b0;
        repeat (4) @(negedge clk);

        FS02 = 1'b1;
        repeat (2) @(negedge clk);
        chk("edge1_before_latency_FS", 32'(FS), 32'h000);
        @(negedge clk);
        chk("edge1_FS", 32'(FS), 32'h001);
        chk("edge1_FA", 32'(FA), 32'h001);
        chk("edge1_FB", 32'(FB), 32'h000);
        @(negedge clk);
        chk("edge1_FA_one_cycle", 32'(FA), 32'h000);
        FS02 = 1'b0;
        repeat (4) @(negedge clk);

        FS02 = 1'b1;
        repeat (3) @(negedge clk);
        chk("edge2_FS", 32'(FS), 32'h002);
        chk("edge2_FA", 32'(FA), 32'h002);
        chk("edge2_FB", 32'(FB), 32'h001);
        @(negedge clk);
        FS02 = 1'b0;
        repeat (4) @(negedge clk);

        hold = 1'b1;
        FS02 = 1'b1;
        repeat (4) @(negedge clk);
        hold = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_edge_dropped_FS", 32'(FS), 32'h002);
        FS02 = 1'b0;
        repeat (4) @(negedge clk);
        edge_cycle();
        chk("after_hold_next_edge_FS", 32'(FS), 32'h003);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        carry_cnt = 0;
        for (int i = 0; i < 4096; i++) edge_cycle();
        chk("wrap_FS", 32'(FS), 32'h000);
        chk("wrap_carry_count", 32'(carry_cnt), 32'd1);
        chk("wrap_FB", 32'(fb_at_carry), 32'hFFF);

        for (int i = 0; i < 1445; i++) edge_cycle();
        chk("pre_reset_FS", 32'(FS), 32'h5A5);
        FS02 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vs_edge_FS", 32'(FS), 32'h000);
        chk("rst_vs_edge_FA", 32'(FA), 32'h000);
        chk("rst_vs_edge_FB", 32'(FB), 32'h000);
        chk("rst_vs_edge_CARRY", 32'(CARRY), 32'h0);
        rst = 1'b0;
        FS02 = 1'b0;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
